parcare_ctrl: RTL and testbench

// - Parking access controller; produces bariera, afisare_locuri, parcare_full for the output interface/monitor.
// - Accepts entry/exit requests and card validation, pulses the barrier, waits for the car to pass, then

---
 rtl/parcare_ctrl.sv | 112 +++++++++++
 tb/tb_parcare_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/parcare_ctrl.sv
// Parking access controller: arbitrates entry/exit requests, pulses the barrier,
// waits for the car to pass and keeps the occupied-space count.
module parcare_ctrl #(
  parameter int unsigned NR_LOCURI = 255,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cerere_intrare_i,
  input  logic       card_valid_i,
  input  logic       cerere_iesire_i,
  input  logic       masina_trecut_i,
  output logic       bariera_o,
  output logic [7:0] afisare_locuri_o,
  output logic       parcare_full_o,
  output logic       acces_refuzat_o
);

  localparam int unsigned CW = 8;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    DESCHIDE_IN,
    ASTEAPTA_IN,
    DESCHIDE_OUT,
    ASTEAPTA_OUT
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] count_q, count_d;
  logic          bariera_q, bariera_d;
  logic          refuz_q, refuz_d;
  logic          full_q, full_d;

  // Next-state, count and registered-output decode
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    bariera_d = 1'b0;
    refuz_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cerere_iesire_i) begin
          if (count_q != '0) begin
            state_d   = DESCHIDE_OUT;
            bariera_d = 1'b1;
          end else begin
            refuz_d = 1'b1;
          end
        end else if (cerere_intrare_i) begin
          if (card_valid_i && !full_q) begin
            state_d   = DESCHIDE_IN;
            bariera_d = 1'b1;
          end else begin
            refuz_d = 1'b1;
          end
        end
      end
      DESCHIDE_IN: begin
        state_d = ASTEAPTA_IN;
        timer_d = TW'(TIMEOUT);
      end
      DESCHIDE_OUT: begin
        state_d = ASTEAPTA_OUT;
        timer_d = TW'(TIMEOUT);
      end
      ASTEAPTA_IN, ASTEAPTA_OUT: begin
        if (masina_trecut_i) begin
          count_d = (state_q == ASTEAPTA_IN) ? count_q + CW'(1) : count_q - CW'(1);
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TW'(1)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Full flag registered from the next count so it aligns with the displayed count
  assign full_d = (count_d == CW'(NR_LOCURI));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      bariera_q <= 1'b0;
      refuz_q   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      bariera_q <= bariera_d;
      refuz_q   <= refuz_d;
      full_q    <= full_d;
    end
  end

  assign bariera_o        = bariera_q;
  assign afisare_locuri_o = count_q;
  assign parcare_full_o   = full_q;
  assign acces_refuzat_o  = refuz_q;

endmodule

// File: tb/tb_parcare_ctrl.sv
// Directed bench: instance a (3 spaces) for full/exit-refusal cases, instance b (255 spaces) for the rest.
module tb_parcare_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic cin, card, cout, mas;
  logic en_a, en_b;

  logic       bar_a, full_a, ref_a;
  logic [7:0] cnt_a;
  logic       bar_b, full_b, ref_b;
  logic [7:0] cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parcare_ctrl #(.NR_LOCURI(3), .TIMEOUT(16)) dut_a (
    .clk_i            (clk),
    .reset_i          (reset),
    .cerere_intrare_i (cin & en_a),
    .card_valid_i     (card & en_a),
    .cerere_iesire_i  (cout & en_a),
    .masina_trecut_i  (mas & en_a),
    .bariera_o        (bar_a),
    .afisare_locuri_o (cnt_a),
    .parcare_full_o   (full_a),
    .acces_refuzat_o  (ref_a)
  );

  parcare_ctrl #(.NR_LOCURI(255), .TIMEOUT(16)) dut_b (
    .clk_i            (clk),
    .reset_i          (reset),
    .cerere_intrare_i (cin & en_b),
    .card_valid_i     (card & en_b),
    .cerere_iesire_i  (cout & en_b),
    .masina_trecut_i  (mas & en_b),
    .bariera_o        (bar_b),
    .afisare_locuri_o (cnt_b),
    .parcare_full_o   (full_b),
    .acces_refuzat_o  (ref_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full entry or exit transaction: request, barrier cycle, one wait cycle, car passes
  task automatic do_trans(input logic is_exit);
    if (is_exit) cout = 1'b1;
    else begin cin = 1'b1; card = 1'b1; end
    tick();
    cin = 1'b0; card = 1'b0; cout = 1'b0;
    tick();
    mas = 1'b1;
    tick();
    mas = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cin = 1'b0; card = 1'b0; cout = 1'b0; mas = 1'b0;
    en_a = 1'b0; en_b = 1'b1;
    tick(); tick();
    reset = 1'b1;
    chk("rst_cnt_b", cnt_b, 8'd0);
    chk("rst_bar_b", {7'd0, bar_b}, 8'd0);
    chk("rst_full_b", {7'd0, full_b}, 8'd0);
    chk("rst_ref_b", {7'd0, ref_b}, 8'd0);
    chk("rst_cnt_a", cnt_a, 8'd0);
    chk("rst_full_a", {7'd0, full_a}, 8'd0);

    // Valid entry, car passes two cycles after the barrier pulse
    cin = 1'b1; card = 1'b1;
    tick();
    chk("entry_bar_on", {7'd0, bar_b}, 8'd1);
    cin = 1'b0; card = 1'b0;
    tick();
    chk("entry_bar_off", {7'd0, bar_b}, 8'd0);
    tick();
    chk("entry_cnt_wait", cnt_b, 8'd0);
    mas = 1'b1;
    tick();
    mas = 1'b0;
    chk("entry_cnt1", cnt_b, 8'd1);
    chk("entry_bar_idle", {7'd0, bar_b}, 8'd0);

    // Invalid card is refused
    cin = 1'b1; card = 1'b0;
    tick();
    chk("badcard_ref", {7'd0, ref_b}, 8'd1);
    chk("badcard_bar", {7'd0, bar_b}, 8'd0);
    cin = 1'b0;
    tick();
    chk("badcard_ref_end", {7'd0, ref_b}, 8'd0);
    chk("badcard_cnt", cnt_b, 8'd1);

    // Timeout: 16 waiting edges, a request held during the wait is ignored until IDLE
    cin = 1'b1; card = 1'b1;
    tick();
    chk("to_bar_on", {7'd0, bar_b}, 8'd1);
    cin = 1'b0; card = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_cnt_wait", cnt_b, 8'd1);
    cin = 1'b1; card = 1'b1;
    tick();
    chk("to_bar_ignored", {7'd0, bar_b}, 8'd0);
    chk("to_cnt_same", cnt_b, 8'd1);
    tick();
    chk("to_idle_bar", {7'd0, bar_b}, 8'd1);
    cin = 1'b0; card = 1'b0;
    tick();
    mas = 1'b1;
    tick();
    mas = 1'b0;
    chk("to_cnt2", cnt_b, 8'd2);

    // Fill to 5, then simultaneous entry+exit serves the exit
    for (int i = 0; i < 3; i++) do_trans(1'b0);
    chk("cnt5", cnt_b, 8'd5);
    cin = 1'b1; card = 1'b1; cout = 1'b1;
    tick();
    chk("both_bar", {7'd0, bar_b}, 8'd1);
    cin = 1'b0; card = 1'b0; cout = 1'b0;
    tick();
    mas = 1'b1;
    tick();
    mas = 1'b0;
    chk("both_cnt4", cnt_b, 8'd4);

    // Reset during the entry wait aborts it
    cin = 1'b1; card = 1'b1;
    tick();
    cin = 1'b0; card = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_cnt", cnt_b, 8'd0);
    chk("midrst_bar", {7'd0, bar_b}, 8'd0);
    mas = 1'b1;
    tick();
    mas = 1'b0;
    chk("midrst_idle_mas", cnt_b, 8'd0);

    // Instance a: three spaces
    en_a = 1'b1; en_b = 1'b0;
    cout = 1'b1;
    tick();
    chk("exit0_ref", {7'd0, ref_a}, 8'd1);
    chk("exit0_bar", {7'd0, bar_a}, 8'd0);
    tick();
    chk("exit0_ref_held", {7'd0, ref_a}, 8'd1);
    cout = 1'b0;
    tick();
    chk("exit0_ref_end", {7'd0, ref_a}, 8'd0);
    chk("exit0_cnt", cnt_a, 8'd0);

    do_trans(1'b0);
    do_trans(1'b0);
    chk("fill_cnt2", cnt_a, 8'd2);
    chk("fill_notfull", {7'd0, full_a}, 8'd0);
    do_trans(1'b0);
    chk("fill_cnt3", cnt_a, 8'd3);
    chk("fill_full", {7'd0, full_a}, 8'd1);

    cin = 1'b1; card = 1'b1;
    tick();
    chk("full_ref", {7'd0, ref_a}, 8'd1);
    chk("full_bar", {7'd0, bar_a}, 8'd0);
    cin = 1'b0; card = 1'b0;
    tick();
    chk("full_cnt", cnt_a, 8'd3);
    chk("full_ref_end", {7'd0, ref_a}, 8'd0);

    do_trans(1'b1);
    chk("exit_cnt2", cnt_a, 8'd2);
    chk("exit_notfull", {7'd0, full_a}, 8'd0);
    do_trans(1'b1);
    chk("exit_cnt1", cnt_a, 8'd1);
    chk("exit_full1", {7'd0, full_a}, 8'd0);

    mas = 1'b1;
    tick();
    mas = 1'b0;
    chk("idle_mas_cnt", cnt_a, 8'd1);
    chk("b_untouched", cnt_b, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
